// File: rtl/dds_sample_sink.sv
// dds_sample_sink
//   Consumer end of the sampling-control strobe interface. Ready starts or
//   restarts the DDS phase accumulator. Each accepted Enable strobe adds
//   Tuning to the phase. The top OUT_W bits of the new phase go into a small
//   FIFO that is drained with a valid/ready handshake. Any change of Mode
//   while running causes a one-cycle FLUSH.
//
//   Ports
//     Fg_CLK, RESETn            clock (posedge) and async active-low reset
//     Ready, Enable, Mode       start pulse, sample strobe, decimation mode
//     Tuning                    phase increment, sampled on each accepted Enable
//     Sample_valid/_ready/_phase  FIFO head handshake and registered data
//     Running                   high while in RUN
//     Overflow                  one-cycle pulse for each dropped sample
//     Drop_count                saturating drop counter (DDS_DROP_CNT_EN only)
//
//   Build option: define DDS_DROP_CNT_EN to add the Drop_count port and its counter.
module dds_sample_sink #(
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               Fg_CLK,
    input  logic               RESETn,
    input  logic               Ready,
    input  logic               Enable,
    input  logic [3:0]         Mode,
    input  logic [PHASE_W-1:0] Tuning,
    output logic               Sample_valid,
    input  logic               Sample_ready,
    output logic [OUT_W-1:0]   Sample_phase,
    output logic               Running,
    output logic               Overflow
`ifdef DDS_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]   Drop_count
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d, phase_sum;
    logic [3:0]          mode_q, mode_d;
    logic [OUT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [FCNT_W-1:0]   cnt_q, cnt_d, remain;
    logic [OUT_W-1:0]    push_word, head_d;
    logic                clr, accept, push, pop, drop, full, valid_d;

    assign phase_sum = phase_q + Tuning;
    assign push_word = phase_sum[PHASE_W-1 -: OUT_W];

    // Control FSM: priority in RUN is Ready > Mode change > Enable
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        clr     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                mode_d = Mode;
                if (Ready) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (Ready) begin
                    phase_d = '0;
                    clr     = 1'b1;
                end else if (Mode != mode_q) begin
                    state_d = FLUSH;
                end else if (Enable) begin
                    accept  = 1'b1;
                    phase_d = phase_sum;
                end
            end
            FLUSH: begin
                clr     = 1'b1;
                phase_d = '0;
                mode_d  = Mode;
                state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; clear wins over pop, a full FIFO accepts a push only alongside a pop
    always_comb begin
        full   = (cnt_q == FCNT_W'(FIFO_DEPTH));
        pop    = !clr && (cnt_q != '0) && Sample_ready;
        push   = accept && (!full || pop);
        drop   = accept && full && !pop;
        remain = cnt_q - FCNT_W'(pop);
        if (clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            rd_d  = rd_q + PTR_W'(pop);
            wr_d  = wr_q + PTR_W'(push);
            cnt_d = remain + FCNT_W'(push);
        end
        // A word pushed into an otherwise empty FIFO is visible on the next cycle
        head_d  = (remain == '0) ? push_word : mem_q[rd_d];
        valid_d = (cnt_d != '0);
    end

    // State, accumulator and FIFO pointers
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            phase_q <= '0;
            mode_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge Fg_CLK) begin
        if (push) mem_q[wr_q] <= push_word;
    end

    // Registered outputs; Sample_phase holds its last value while empty
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            Sample_valid <= 1'b0;
            Sample_phase <= '0;
            Running      <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            Sample_valid <= valid_d;
            if (valid_d) Sample_phase <= head_d;
            Running      <= (state_d == RUN);
            Overflow     <= drop;
        end
    end

`ifdef DDS_DROP_CNT_EN
    // Saturating drop counter, cleared only by reset
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn)                        Drop_count <= '0;
        else if (drop && Drop_count != '1)  Drop_count <= Drop_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_dds_sample_sink.sv
// tb_dds_sample_sink
//   Directed and random stimulus for dds_sample_sink. Expected outputs come
//   from a queue-based reference model of the sink's behaviour.
module tb_dds_sample_sink;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned OUT_W   = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;

    logic               Fg_CLK       = 1'b0;
    logic               RESETn       = 1'b0;
    logic               Ready        = 1'b0;
    logic               Enable       = 1'b0;
    logic [3:0]         Mode         = 4'd0;
    logic [PHASE_W-1:0] Tuning       = '0;
    logic               Sample_ready = 1'b0;
    logic               Sample_valid;
    logic [OUT_W-1:0]   Sample_phase;
    logic               Running;
    logic               Overflow;
`ifdef DDS_DROP_CNT_EN
    logic [CNT_W-1:0]   Drop_count;
`endif

    dds_sample_sink #(
        .PHASE_W(PHASE_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .Fg_CLK       (Fg_CLK),
        .RESETn       (RESETn),
        .Ready        (Ready),
        .Enable       (Enable),
        .Mode         (Mode),
        .Tuning       (Tuning),
        .Sample_valid (Sample_valid),
        .Sample_ready (Sample_ready),
        .Sample_phase (Sample_phase),
        .Running      (Running),
        .Overflow     (Overflow)
`ifdef DDS_DROP_CNT_EN
        ,
        .Drop_count   (Drop_count)
`endif
    );

    always #5 Fg_CLK = ~Fg_CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: started/flushing flags, phase value, word queue
    bit               m_started;
    bit               m_flushing;
    logic [3:0]       m_mode;
    logic [31:0]      m_acc;
    logic [OUT_W-1:0] m_q[$];
    logic [OUT_W-1:0] m_last;
    bit               m_ovf;
    int               m_drops;
    int               ovf_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_flushing = 1'b0;
        m_mode     = 4'd0;
        m_acc      = 32'd0;
        m_q.delete();
        m_last     = '0;
        m_ovf      = 1'b0;
        m_drops    = 0;
    endtask

    // One clock of the sink's rules, applied to the inputs currently driven
    task automatic model_step();
        m_ovf = 1'b0;
        if (!m_started) begin
            m_mode = Mode;
            if (Ready) begin
                m_started = 1'b1;
                m_acc     = 32'd0;
            end
        end else if (m_flushing) begin
            m_q.delete();
            m_acc      = 32'd0;
            m_mode     = Mode;
            m_flushing = 1'b0;
        end else if (Ready) begin
            m_acc = 32'd0;
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && Sample_ready) void'(m_q.pop_front());
            if (Mode != m_mode) begin
                m_flushing = 1'b1;
            end else if (Enable) begin
                m_acc = m_acc + Tuning;
                if (m_q.size() < DEPTH) m_q.push_back(m_acc[31:20]);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},   32'(Sample_valid), 32'(m_q.size() > 0));
        chk({tag, ".phase"},   32'(Sample_phase), 32'(m_last));
        chk({tag, ".running"}, 32'(Running),      32'(m_started && !m_flushing));
        chk({tag, ".ovf"},     32'(Overflow),     32'(m_ovf));
`ifdef DDS_DROP_CNT_EN
        chk({tag, ".drops"},   32'(Drop_count),   32'(m_drops));
`endif
        if (Overflow === 1'b1) ovf_seen++;
    endtask

    task automatic step(input logic rdy, input logic en, input logic [3:0] md,
                        input logic [31:0] tun, input logic srdy, input string tag);
        Ready        = rdy;
        Enable       = en;
        Mode         = md;
        Tuning       = tun;
        Sample_ready = srdy;
        model_step();
        @(posedge Fg_CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs("reset");
        #10 RESETn = 1'b1;

        // Enable before any Ready is ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b1, "idle_en");
        chk("idle_valid", 32'(Sample_valid), 32'd0);
        chk("idle_running", 32'(Running), 32'd0);

        // Start, three samples drained immediately
        step(1'b1, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "start");
        chk("start_running", 32'(Running), 32'd1);
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b1, "s1");
        chk("s1_word", 32'(Sample_phase), 32'h100);
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b1, "s2");
        chk("s2_word", 32'(Sample_phase), 32'h200);
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b1, "s3");
        chk("s3_word", 32'(Sample_phase), 32'h300);
        step(1'b0, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "drain");
        chk("drain_valid", 32'(Sample_valid), 32'd0);

        // Six samples with no pops: four kept, two dropped
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b0, "fill");
        chk("fill_ovf_pulses", 32'(ovf_seen), 32'd2);
        chk("fill_head", 32'(Sample_phase), 32'h400);
`ifdef DDS_DROP_CNT_EN
        chk("fill_drop_count", 32'(Drop_count), 32'd2);
`endif

        // Full FIFO, push and pop together: no drop, order kept
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b1, "full_pp");
        chk("full_pp_ovf", 32'(Overflow), 32'd0);
        chk("full_pp_head", 32'(Sample_phase), 32'h500);
        step(1'b0, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "pop_a");
        chk("pop_a_head", 32'(Sample_phase), 32'h600);
        step(1'b0, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "pop_b");
        chk("pop_b_head", 32'(Sample_phase), 32'h700);
        step(1'b0, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "pop_c");
        chk("pop_c_head", 32'(Sample_phase), 32'hA00);
        step(1'b0, 1'b0, 4'd0, 32'h1000_0000, 1'b1, "pop_d");

        // Mode change with two words queued
        step(1'b1, 1'b0, 4'd0, 32'h1000_0000, 1'b0, "restart");
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b0, "q1");
        step(1'b0, 1'b1, 4'd0, 32'h1000_0000, 1'b0, "q2");
        step(1'b0, 1'b0, 4'd2, 32'h1000_0000, 1'b0, "mode_chg");
        chk("flush_running", 32'(Running), 32'd0);
        step(1'b0, 1'b1, 4'd2, 32'h1000_0000, 1'b0, "flush");
        chk("post_flush_running", 32'(Running), 32'd1);
        chk("post_flush_valid", 32'(Sample_valid), 32'd0);
        step(1'b0, 1'b1, 4'd2, 32'h1000_0000, 1'b1, "after_flush");
        chk("after_flush_word", 32'(Sample_phase), 32'h100);

        // Wrap-around of the accumulator
        step(1'b1, 1'b0, 4'd2, 32'hFFFF_FFFF, 1'b1, "wrap_start");
        step(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 1'b1, "wrap1");
        chk("wrap1_word", 32'(Sample_phase), 32'hFFF);
        step(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 1'b1, "wrap2");
        chk("wrap2_word", 32'(Sample_phase), 32'hFFF);
        chk("wrap2_ovf", 32'(Overflow), 32'd0);
        step(1'b0, 1'b1, 4'd2, 32'h0000_0002, 1'b1, "wrap3");
        chk("wrap3_word", 32'(Sample_phase), 32'h000);

        // Asynchronous reset mid-operation, then Mode change in IDLE causes no flush
        step(1'b0, 1'b1, 4'd2, 32'h1000_0000, 1'b0, "pre_rst");
        RESETn = 1'b0;
        #2;
        model_reset();
        check_outputs("mid_reset");
        #2 RESETn = 1'b1;
        step(1'b0, 1'b0, 4'd5, 32'h1000_0000, 1'b0, "idle_mode");
        step(1'b1, 1'b0, 4'd5, 32'h1000_0000, 1'b0, "start2");
        step(1'b0, 1'b1, 4'd5, 32'h1000_0000, 1'b0, "no_flush");
        chk("no_flush_running", 32'(Running), 32'd1);
        chk("no_flush_word", 32'(Sample_phase), 32'h100);

        // Random traffic against the model
        begin
            logic [3:0] md;
            md = 4'd5;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) md = 4'($urandom_range(0, 3));
                step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), md,
                     $urandom, 1'($urandom_range(0, 2) == 0), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
